// File: rtl/counter_setup_seq.sv
// counter_setup_seq: FIFO-fed sequencer for the period counter. Each queued entry
// drives the counter's setup/direction for a programmed number of full periods.
module counter_setup_seq #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int REPEAT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [WIDTH-1:0]        i_setup,
  input  logic                    i_desc,
  input  logic [REPEAT_W-1:0]     i_repeat,
  output logic                    o_cnt_rst_n,
  output logic [WIDTH-1:0]        o_setup,
  output logic                    o_desc,
  input  logic                    i_match,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [REPEAT_W-1:0]     o_remaining,
  output logic                    o_err,
  input  logic                    i_err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // state | meaning
  // IDLE  | counter held in reset, waiting for enable and a queued entry
  // LOAD  | one cycle: new config presented while the counter is still in reset
  // RUN   | counter released, periods counted on i_match
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mem_setup [DEPTH];
  logic [REPEAT_W-1:0] mem_rep   [DEPTH];
  logic [DEPTH-1:0]    mem_desc_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [WIDTH-1:0]    setup_q;
  logic                desc_q;
  logic [REPEAT_W-1:0] remaining_q;
  logic                cnt_rst_n_q;
  logic                done_q;
  logic                err_q;

  logic                full, empty, hs, push, pop, last_period;
  logic [REPEAT_W-1:0] head_rep;

  assign full        = (level_q == LW'(DEPTH));
  assign empty       = (level_q == '0);
  assign hs          = i_valid & ~full;
  assign push        = hs & (i_setup != '0);
  assign last_period = (remaining_q <= REPEAT_W'(1));
  assign pop         = ~empty & i_enable &
                       ((state_q == S_IDLE) | ((state_q == S_RUN) & i_match & last_period));
  // A zero repeat count still runs one period.
  assign head_rep    = (mem_rep[rd_ptr_q] == '0) ? REPEAT_W'(1) : mem_rep[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_setup[wr_ptr_q] <= i_setup;
      mem_rep[wr_ptr_q]   <= i_repeat;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_desc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q             <= wr_ptr_q + AW'(1);
        mem_desc_q[wr_ptr_q] <= i_desc;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (hs && (i_setup == '0)) err_q <= 1'b1;
      else if (i_err_clr)        err_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      setup_q     <= '0;
      desc_q      <= 1'b0;
      remaining_q <= '0;
      cnt_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_rst_n_q <= 1'b0;
          if (pop) begin
            setup_q     <= mem_setup[rd_ptr_q];
            desc_q      <= mem_desc_q[rd_ptr_q];
            remaining_q <= head_rep;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!i_enable) begin
            remaining_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_rst_n_q <= 1'b1;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (!i_enable) begin
            remaining_q <= '0;
            cnt_rst_n_q <= 1'b0;
            state_q     <= S_IDLE;
          end else if (i_match) begin
            if (!last_period) begin
              remaining_q <= remaining_q - REPEAT_W'(1);
            end else if (pop) begin
              setup_q     <= mem_setup[rd_ptr_q];
              desc_q      <= mem_desc_q[rd_ptr_q];
              remaining_q <= head_rep;
              cnt_rst_n_q <= 1'b0;
              state_q     <= S_LOAD;
            end else begin
              remaining_q <= '0;
              cnt_rst_n_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          cnt_rst_n_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready     = ~full;
  assign o_cnt_rst_n = cnt_rst_n_q;
  assign o_setup     = setup_q;
  assign o_desc      = desc_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_level     = level_q;
  assign o_remaining = remaining_q;
  assign o_err       = err_q;

endmodule
